shifter_arbiter: RTL
====================

Name: shifter_arbiter

Overview:
Sequencer and arbiter that shares one combinational 32-bit logical-left barrel shifter (5-stage, Enable-gated, zero output when disabled) between two requesters, A and B. Each requester presents an operand and a 5-bit shift amount over a valid/ready handshake and gets its result back over a valid/ready response channel. The block drives the shifter's In1/In2/Enable inputs and registers its Out. It sits between the ALU issue logic and the shared shifter instance.

Parameters:
CNT_W, 16, width of the completed-operation counter (wraps modulo 2^CNT_W)

Ports:
Clk  input  1  single clock, all state updates on rising edge
Rst  input  1  synchronous, active-high reset
ReqValidA  input  1  requester A has an operation
ReqReadyA  output  1  A's operation accepted this cycle
ReqDataA  input  32  A operand (shifted value)
ReqAmtA  input  5  A shift amount
RspValidA  output  1  result for A available
RspReadyA  input  1  A consumes result
ReqValidB, ReqReadyB, ReqDataB, ReqAmtB, RspValidB, RspReadyB  same as A, for requester B
RspData  output  32  result data (shared; qualified by RspValidA/RspValidB)
ShIn1  output  32  to shifter In1
ShIn2  output  32  to shifter In2 (upper 27 bits always 0)
ShEnable  output  1  to shifter Enable
ShOut  input  32  from shifter Out
Busy  output  1  high whenever state != IDLE
OpCount  output  CNT_W  number of completed responses

Behaviour:
- Reset (Rst=1 at a clock edge), from any state including mid-operation: state=IDLE, Prio=A, operand/amount/result regs=0, Owner=A, OpCount=0, all pending work dropped. Outputs after reset: ReqReadyA/B=0 unless granted in IDLE, RspValidA/B=0, RspData=0, ShIn1=0, ShIn2=0, ShEnable=0, Busy=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, grant logic (combinational): only A valid -> grant A; only B valid -> grant B; both valid -> grant Prio; neither -> no grant. ReqReadyX=1 only in IDLE for the granted X. ReqReady may depend combinationally on ReqValid; ReqValid must not depend on ReqReady.
- On a grant edge: latch OpReg<=ReqDataX, AmtReg<=ReqAmtX, Owner<=X, Prio<=other(X), state->ISSUE. A non-granted requester holds ReqValid and its data; it is never acknowledged.
- ISSUE (exactly 1 cycle): ShIn1=OpReg, ShIn2={27'b0,AmtReg}, ShEnable=1. At the edge: ResReg<=ShOut, state->RESP. ShIn1/ShIn2 read 0 and ShEnable reads 0 in every other state.
- RESP: RspValid[Owner]=1, the other RspValid=0, RspData=ResReg. Held stable until RspReady[Owner]=1. On that edge: OpCount<=OpCount+1 (wraps), state->IDLE. RspReady from the non-owner is ignored.
- RspData=ResReg at all times, so it reads 0 after reset and keeps the last result in IDLE/ISSUE.
- Latency: accept edge N -> ISSUE during cycle N+1 -> RspValid during cycle N+2. With immediate RspReady, the next accept is possible at edge N+3, giving 1 op per 3 cycles peak.
- No new request is accepted while in ISSUE/RESP; ReqReadyA=ReqReadyB=0 in those states.
- Shift amount: 0..31, logical left, zero fill. Amount 0 returns the operand unchanged.
- Fairness: with both requesters continuously valid, grants alternate A,B,A,B..., starting from Prio.

Test Plan:
- Reset then A only: ReqDataA=0x00000001, ReqAmtA=31, RspReadyA=1 -> ReqReadyA pulses 1 cycle; RspValidA high 2 cycles after accept; RspData=0x80000000; OpCount=1; RspValidB never asserts.
- Both valid continuously: A=0xF0F0F0F0/4, B=0x12345678/8, ready always 1 -> grant order A,B,A,B; results 0x0F0F0F00 (A) and 0x34567800 (B); accepts spaced 3 cycles; OpCount=4 after 4 responses.
- Response backpressure: B=0xFFFFFFFF/0, RspReadyB=0 for 5 cycles -> RspValidB and RspData=0xFFFFFFFF stable for 5 cycles; ReqValidA held meanwhile is not accepted until the cycle after RspReadyB=1.
- ShEnable/ShIn checks: across any op, ShEnable=1 exactly one cycle (ISSUE) with ShIn1=operand and ShIn2=amount; ShEnable=0, ShIn1=0, ShIn2=0 otherwise.
- Reset mid-operation: assert Rst during ISSUE, then during RESP -> next cycle state IDLE, RspValidA/B=0, RspData=0, OpCount=0, Prio=A (both valid afterwards -> A granted first).
- Counter wrap: CNT_W=2, complete 5 ops -> OpCount sequence 1,2,3,0,1.

Source files
------------

// File: rtl/shifter_arbiter.sv
// Two-requester sequencer that time-shares one external 32-bit left shifter.
// Fixed 3-state pipeline: accept in IDLE, drive shifter in ISSUE, hold result in RESP.
module shifter_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ReqValidA,
    output logic             ReqReadyA,
    input  logic [31:0]      ReqDataA,
    input  logic [4:0]       ReqAmtA,
    output logic             RspValidA,
    input  logic             RspReadyA,
    input  logic             ReqValidB,
    output logic             ReqReadyB,
    input  logic [31:0]      ReqDataB,
    input  logic [4:0]       ReqAmtB,
    output logic             RspValidB,
    input  logic             RspReadyB,
    output logic [31:0]      RspData,
    output logic [31:0]      ShIn1,
    output logic [31:0]      ShIn2,
    output logic             ShEnable,
    input  logic [31:0]      ShOut,
    output logic             Busy,
    output logic [CNT_W-1:0] OpCount
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t           state;
    logic             prio_b;
    logic             owner_b;
    logic [31:0]      op_reg;
    logic [4:0]       amt_reg;
    logic [31:0]      res_reg;
    logic             sh_en;
    logic             rsp_a;
    logic             rsp_b;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic             grant_a;
    logic             grant_b;
    logic             rsp_take;

    // Ties go to prio_b; a lone requester always wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            grant_a = ReqValidA && (!ReqValidB || !prio_b);
            grant_b = ReqValidB && (!ReqValidA || prio_b);
        end
    end

    assign rsp_take = owner_b ? RspReadyB : RspReadyA;

    // Operand/amount regs are cleared after ISSUE so the shifter sees 0 elsewhere.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            prio_b   <= 1'b0;
            owner_b  <= 1'b0;
            op_reg   <= '0;
            amt_reg  <= '0;
            res_reg  <= '0;
            sh_en    <= 1'b0;
            rsp_a    <= 1'b0;
            rsp_b    <= 1'b0;
            busy     <= 1'b0;
            op_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        state   <= ISSUE;
                        owner_b <= grant_b;
                        prio_b  <= grant_a;
                        op_reg  <= grant_b ? ReqDataB : ReqDataA;
                        amt_reg <= grant_b ? ReqAmtB : ReqAmtA;
                        sh_en   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ISSUE: begin
                    state   <= RESP;
                    res_reg <= ShOut;
                    sh_en   <= 1'b0;
                    op_reg  <= '0;
                    amt_reg <= '0;
                    rsp_a   <= !owner_b;
                    rsp_b   <= owner_b;
                end
                RESP: begin
                    if (rsp_take) begin
                        state    <= IDLE;
                        rsp_a    <= 1'b0;
                        rsp_b    <= 1'b0;
                        busy     <= 1'b0;
                        op_count <= op_count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ReqReadyA = grant_a;
    assign ReqReadyB = grant_b;
    assign RspValidA = rsp_a;
    assign RspValidB = rsp_b;
    assign RspData   = res_reg;
    assign ShIn1     = op_reg;
    assign ShIn2     = {27'b0, amt_reg};
    assign ShEnable  = sh_en;
    assign Busy      = busy;
    assign OpCount   = op_count;

endmodule
